// File: rtl/multi_lifo.sv
// NCH independent LIFO stacks of 2**AWIDTH words sharing one memory, addressed {channel, slot}.
// Pop data is registered (valid one cycle after accept); no backpressure: rejected requests pulse ovf_o/udf_o.
module multi_lifo #(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 4,
  parameter int NCH          = 4,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2,
  localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int UW          = AWIDTH + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wrreq_i,
  input  logic [CHW-1:0]    wr_ch_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  input  logic [CHW-1:0]    rd_ch_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              q_valid_o,
  output logic [NCH-1:0]    empty_o,
  output logic [NCH-1:0]    almost_empty_o,
  output logic [NCH-1:0]    full_o,
  output logic [NCH-1:0]    almost_full_o,
  output logic [NCH*UW-1:0] usedw_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int D   = 1 << AWIDTH;
  localparam int MW  = CHW + AWIDTH;
  localparam int CW1 = CHW + 1;

  localparam logic [UW-1:0]  FULL_LVL = UW'(D);
  localparam logic [UW-1:0]  AF_LVL   = UW'(D - ALMOST_FULL);
  localparam logic [UW-1:0]  AE_LVL   = UW'(ALMOST_EMPTY);
  localparam logic [CW1-1:0] NCH_LVL  = CW1'(NCH);

  logic [DWIDTH-1:0] mem [2**MW];

  logic [UW-1:0]     used_q   [NCH];
  logic [UW-1:0]     used_nxt [NCH];
  logic [UW-1:0]     wr_used;
  logic [UW-1:0]     rd_used;
  logic              wr_in;
  logic              rd_in;
  logic              pop_acc;
  logic              push_acc;
  logic              replace;
  logic              ovf_nxt;
  logic              udf_nxt;
  logic [MW-1:0]     wr_addr;
  logic [MW-1:0]     rd_addr;

  // Fill level of the addressed channels; out-of-range channels read as 0 and are gated below.
  always_comb begin
    wr_used = '0;
    rd_used = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_ch_i == CHW'(c)) wr_used = used_q[c];
      if (rd_ch_i == CHW'(c)) rd_used = used_q[c];
    end
  end

  always_comb begin
    wr_in    = {1'b0, wr_ch_i} < NCH_LVL;
    rd_in    = {1'b0, rd_ch_i} < NCH_LVL;
    pop_acc  = rdreq_i && rd_in && (rd_used != '0);
    // A same-channel push+pop on a non-empty stack swaps the top word, so it is legal even when full.
    replace  = pop_acc && wrreq_i && wr_in && (wr_ch_i == rd_ch_i);
    push_acc = wrreq_i && wr_in && ((wr_used != FULL_LVL) || replace);
    ovf_nxt  = wrreq_i && wr_in && !push_acc;
    udf_nxt  = rdreq_i && rd_in && !pop_acc;
    rd_addr  = {rd_ch_i, AWIDTH'(rd_used - UW'(1))};
    wr_addr  = replace ? {wr_ch_i, AWIDTH'(wr_used - UW'(1))}
                       : {wr_ch_i, AWIDTH'(wr_used)};
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      used_nxt[c] = used_q[c];
      if (push_acc && !replace && (wr_ch_i == CHW'(c))) used_nxt[c] = used_nxt[c] + UW'(1);
      if (pop_acc && !replace && (rd_ch_i == CHW'(c)))  used_nxt[c] = used_nxt[c] - UW'(1);
    end
  end

  // Storage is not reset; stale contents are unreachable once usedw is cleared.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_addr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o       <= '0;
      q_valid_o <= 1'b0;
      ovf_o     <= 1'b0;
      udf_o     <= 1'b0;
    end else begin
      if (pop_acc) q_o <= mem[rd_addr];
      q_valid_o <= pop_acc;
      ovf_o     <= ovf_nxt;
      udf_o     <= udf_nxt;
    end
  end

  // Flags come from next-state fill levels so they move together with usedw_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NCH; c++) used_q[c] <= '0;
      empty_o        <= '1;
      almost_empty_o <= '1;
      full_o         <= '0;
      almost_full_o  <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        used_q[c]         <= used_nxt[c];
        empty_o[c]        <= (used_nxt[c] == '0);
        almost_empty_o[c] <= (used_nxt[c] <= AE_LVL);
        full_o[c]         <= (used_nxt[c] == FULL_LVL);
        almost_full_o[c]  <= (used_nxt[c] >= AF_LVL);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_usedw
    assign usedw_o[g*UW +: UW] = used_q[g];
  end

endmodule

// File: tb/tb_multi_lifo.sv
// Directed bench for multi_lifo: stimulus queues expected pops/pulses, a negedge monitor consumes them.
module tb_multi_lifo;

  localparam int UW = 5;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wrreq_i = 1'b0;
  logic [1:0]  wr_ch_i = '0;
  logic [15:0] data_i = '0;
  logic        rdreq_i = 1'b0;
  logic [1:0]  rd_ch_i = '0;
  logic [15:0] q_o;
  logic        q_valid_o;
  logic [3:0]  empty_o;
  logic [3:0]  almost_empty_o;
  logic [3:0]  full_o;
  logic [3:0]  almost_full_o;
  logic [19:0] usedw_o;
  logic        ovf_o;
  logic        udf_o;

  always #5 clk_i = ~clk_i;

  multi_lifo dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wrreq_i        (wrreq_i),
    .wr_ch_i        (wr_ch_i),
    .data_i         (data_i),
    .rdreq_i        (rdreq_i),
    .rd_ch_i        (rd_ch_i),
    .q_o            (q_o),
    .q_valid_o      (q_valid_o),
    .empty_o        (empty_o),
    .almost_empty_o (almost_empty_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .usedw_o        (usedw_o),
    .ovf_o          (ovf_o),
    .udf_o          (udf_o)
  );

  logic [15:0] exp_q [$];
  int ovf_pend = 0;
  int udf_pend = 0;
  int checks = 0;
  int errors = 0;

  function automatic logic [UW-1:0] used(input int c);
    return usedw_o[c*UW +: UW];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; inputs are released 1 time unit after the edge.
  task automatic op(input logic wr, input logic [1:0] wch, input logic [15:0] d,
                    input logic rd, input logic [1:0] rch);
    wrreq_i = wr;
    wr_ch_i = wch;
    data_i  = d;
    rdreq_i = rd;
    rd_ch_i = rch;
    @(posedge clk_i);
    #1;
    wrreq_i = 1'b0;
    rdreq_i = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [15:0] d);
    op(1'b1, ch, d, 1'b0, 2'd0);
  endtask

  task automatic pop_exp(input logic [1:0] ch, input logic [15:0] e);
    exp_q.push_back(e);
    op(1'b0, 2'd0, 16'h0, 1'b1, ch);
  endtask

  // Monitor: every output pulse must match an outstanding expectation.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk_i);
      if (q_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL q_unexpected: got q_valid with q=%0h, expected no pop result", q_o);
        end else begin
          e = exp_q.pop_front();
          if (q_o !== e) begin
            errors++;
            $display("FAIL q_data: got %0h, expected %0h", q_o, e);
          end
        end
      end
      if (ovf_o) begin
        checks++;
        if (ovf_pend == 0) begin
          errors++;
          $display("FAIL ovf_unexpected: got ovf_o=1, expected 0");
        end else ovf_pend--;
      end
      if (udf_o) begin
        checks++;
        if (udf_pend == 0) begin
          errors++;
          $display("FAIL udf_unexpected: got udf_o=1, expected 0");
        end else udf_pend--;
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_usedw", 32'(usedw_o), 32'h0);
    chk("rst_empty", 32'(empty_o), 32'hF);
    chk("rst_aempty", 32'(almost_empty_o), 32'hF);
    chk("rst_full", 32'(full_o), 32'h0);
    chk("rst_afull", 32'(almost_full_o), 32'h0);
    chk("rst_q", 32'(q_o), 32'h0);
    chk("rst_qvalid", 32'(q_valid_o), 32'h0);
    chk("rst_ovf_udf", {30'h0, ovf_o, udf_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill and drain ch1
    for (int i = 0; i < 16; i++) push(2'd1, 16'h1000 + 16'(i));
    chk("t1_full1", 32'(full_o[1]), 32'h1);
    chk("t1_used1", 32'(used(1)), 32'd16);
    chk("t1_others_empty", 32'(empty_o), 32'hD);
    pop_exp(2'd1, 16'h100F);
    chk("t1_first_qvalid", 32'(q_valid_o), 32'h1);
    chk("t1_first_q", 32'(q_o), 32'h100F);
    for (int i = 1; i < 16; i++) pop_exp(2'd1, 16'h100F - 16'(i));
    chk("t1_empty_end", 32'(empty_o), 32'hF);

    // Overflow on full ch0
    for (int i = 0; i < 16; i++) push(2'd0, 16'h2000 + 16'(i));
    ovf_pend++;
    push(2'd0, 16'hDEAD);
    chk("t2_ovf", 32'(ovf_o), 32'h1);
    chk("t2_used0", 32'(used(0)), 32'd16);
    for (int i = 0; i < 16; i++) pop_exp(2'd0, 16'h200F - 16'(i));
    chk("t2_used0_end", 32'(used(0)), 32'd0);

    // Replace-top on ch2, partially filled then full
    push(2'd2, 16'h0001);
    push(2'd2, 16'h0002);
    push(2'd2, 16'hAAAA);
    exp_q.push_back(16'hAAAA);
    op(1'b1, 2'd2, 16'hBBBB, 1'b1, 2'd2);
    chk("t3_used2_replace", 32'(used(2)), 32'd3);
    pop_exp(2'd2, 16'hBBBB);
    chk("t3_used2_pop", 32'(used(2)), 32'd2);
    for (int i = 0; i < 14; i++) push(2'd2, 16'h3000 + 16'(i));
    chk("t3_full2", 32'(full_o[2]), 32'h1);
    exp_q.push_back(16'h300D);
    op(1'b1, 2'd2, 16'hCCCC, 1'b1, 2'd2);
    chk("t3_full2_replace", 32'(full_o[2]), 32'h1);
    chk("t3_ovf_replace", 32'(ovf_o), 32'h0);
    chk("t3_used2_full", 32'(used(2)), 32'd16);
    pop_exp(2'd2, 16'hCCCC);
    for (int i = 0; i < 13; i++) pop_exp(2'd2, 16'h300C - 16'(i));
    pop_exp(2'd2, 16'h0002);
    pop_exp(2'd2, 16'h0001);

    // Independent push ch3 / pop ch0
    push(2'd0, 16'h0005);
    exp_q.push_back(16'h0005);
    op(1'b1, 2'd3, 16'h7777, 1'b1, 2'd0);
    chk("t4_used0", 32'(used(0)), 32'd0);
    chk("t4_used3", 32'(used(3)), 32'd1);
    pop_exp(2'd3, 16'h7777);

    // Underflow cases on ch1
    udf_pend++;
    op(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
    chk("t5_udf_pop", 32'(udf_o), 32'h1);
    chk("t5_qvalid_pop", 32'(q_valid_o), 32'h0);
    udf_pend++;
    op(1'b1, 2'd1, 16'h4444, 1'b1, 2'd1);
    chk("t5_udf_pushpop", 32'(udf_o), 32'h1);
    chk("t5_qvalid_pushpop", 32'(q_valid_o), 32'h0);
    chk("t5_used1", 32'(used(1)), 32'd1);
    pop_exp(2'd1, 16'h4444);

    // Almost thresholds on ch0, then asynchronous reset mid-stream
    for (int i = 0; i < 13; i++) push(2'd0, 16'h5000 + 16'(i));
    chk("t6_afull_13", 32'(almost_full_o[0]), 32'h0);
    push(2'd0, 16'h500D);
    chk("t6_afull_14", 32'(almost_full_o[0]), 32'h1);
    for (int i = 0; i < 11; i++) pop_exp(2'd0, 16'h500D - 16'(i));
    chk("t6_aempty_3", 32'(almost_empty_o[0]), 32'h0);
    pop_exp(2'd0, 16'h5002);
    chk("t6_aempty_2", 32'(almost_empty_o[0]), 32'h1);
    chk("t6_used0", 32'(used(0)), 32'd2);
    push(2'd3, 16'h6666);
    op(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
    chk("t6_qvalid_pre_rst", 32'(q_valid_o), 32'h1);
    chk("t6_q_pre_rst", 32'(q_o), 32'h5001);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_qvalid", 32'(q_valid_o), 32'h0);
    chk("t6_rst_usedw", 32'(usedw_o), 32'h0);
    chk("t6_rst_empty", 32'(empty_o), 32'hF);

    repeat (3) @(posedge clk_i);
    #1;
    chk("end_exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("end_ovf_pending", 32'(ovf_pend), 32'd0);
    chk("end_udf_pending", 32'(udf_pend), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
